// File: rtl/search_pkg.sv
// Shared types and default sizes for the search_scan linear table search.
package search_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int A_DEF = 4;
  localparam int D_DEF = 8;

endpackage

// File: rtl/search_table.sv
// Key table: DEPTH data words plus per-entry valid flags, one write port and
// one combinational read port.
module search_table
  import search_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic [A-1:0] rd_addr,
  output logic [D-1:0] rd_data,
  output logic         rd_valid
);

  localparam int DEPTH = 1 << A;

  logic [D-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] wr_hit;

  // Data words carry no reset; the valid flags alone decide whether an entry exists.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign wr_hit[gi] = wr_en && (wr_addr == A'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_reg <= '0;
    else        valid_reg <= valid_reg | wr_hit;
  end

  assign rd_data  = mem[rd_addr];
  assign rd_valid = valid_reg[rd_addr];

endmodule

// File: rtl/search_scan.sv
// Sequential key search: scans table entries from index 0 upward, one per
// cycle, and reports the lowest valid index whose data equals the key.
module search_scan
  import search_pkg::*;
#(
  parameter int A = A_DEF,
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         start,
  input  logic [D-1:0] key,
  output logic         busy,
  output logic         done,
  output logic         match,
  output logic         nomatch,
  output logic [A-1:0] match_addr
);

  localparam logic [A-1:0] LAST_IDX = '1;

  state_t       state_reg, state_next;
  logic [A-1:0] idx_reg, idx_next;
  logic [D-1:0] key_reg, key_next;
  logic         match_reg, match_next;
  logic [A-1:0] match_addr_reg, match_addr_next;

  logic [D-1:0] rd_data;
  logic         rd_valid;
  logic         hit;

  search_table #(.A(A), .D(D)) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (idx_reg),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  // The compare sees the table as it was before any write on this same edge.
  assign hit = rd_valid && (rd_data == key_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      key_reg        <= '0;
      match_reg      <= 1'b0;
      match_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      key_reg        <= key_next;
      match_reg      <= match_next;
      match_addr_reg <= match_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    key_next        = key_reg;
    match_next      = match_reg;
    match_addr_next = match_addr_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = SCAN;
          idx_next        = '0;
          key_next        = key;
          match_next      = 1'b0;
          match_addr_next = '0;
        end
      end
      SCAN: begin
        if (hit) begin
          state_next      = DONE;
          match_next      = 1'b1;
          match_addr_next = idx_reg;
        end else if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + A'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state_reg == SCAN);
  assign done       = (state_reg == DONE);
  assign match      = match_reg;
  assign nomatch    = ~match_reg;
  assign match_addr = match_addr_reg;

endmodule

// File: tb/tb_search_scan.sv
// Directed bench for search_scan: table-driven scans plus hand-built sequences
// for mid-scan writes, ignored restarts and asynchronous reset.
module tb_search_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic [7:0] key = '0;
  logic       busy, done, match, nomatch;
  logic [3:0] match_addr;

  int total = 0;
  int passed = 0;

  search_scan #(.A(4), .D(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .nomatch    (nomatch),
    .match_addr (match_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       w1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [7:0] k;
    logic       em;
    logic [3:0] ea;
    int         elat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Start a scan and count edges after the start edge until done is seen.
  // At the cycle after edge ev_at an optional write and/or extra start is driven.
  task automatic run_scan(input logic [7:0] k, input int ev_at,
                          input logic ev_wr, input logic [3:0] ev_addr, input logic [7:0] ev_data,
                          input logic ev_start, input logic [7:0] ev_key,
                          output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; key = k;
    @(posedge clk); #1;
    start = 1'b0;
    key = ~k;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n - 1 == ev_at) begin
        if (ev_wr) begin wr_en = 1'b1; wr_addr = ev_addr; wr_data = ev_data; end
        if (ev_start) begin start = 1'b1; key = ev_key; end
      end
      @(posedge clk); #1;
      wr_en = 1'b0; start = 1'b0;
      if (done) begin lat = n; break; end
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bcnt;

  initial begin
    vecs[0] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0,  16};
    vecs[1] = '{1'b1, 4'd3,  8'h5A, 1'b1, 4'd9, 8'h5A, 8'h5A, 1'b1, 4'd3,  4};
    vecs[2] = '{1'b1, 4'd15, 8'hC3, 1'b0, 4'd0, 8'h00, 8'hC3, 1'b1, 4'd15, 16};
    vecs[3] = '{1'b1, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd0,  1};
    vecs[4] = '{1'b1, 4'd6,  8'h77, 1'b0, 4'd0, 8'h00, 8'h78, 1'b0, 4'd0,  16};
    vecs[5] = '{1'b1, 4'd2,  8'hAA, 1'b1, 4'd2, 8'hBB, 8'hAA, 1'b0, 4'd0,  16};

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_nomatch", nomatch, 1);
    chk("rst_addr", match_addr, 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      if (vecs[i].w0) do_write(vecs[i].a0, vecs[i].d0);
      if (vecs[i].w1) do_write(vecs[i].a1, vecs[i].d1);
      run_scan(vecs[i].k, -1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, lat, bcnt);
      $display("vec %0d key=%02h lat=%0d busy=%0d match=%0b addr=%0d", i, vecs[i].k, lat, bcnt, match, match_addr);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].elat);
      chk($sformatf("v%0d_match", i), match, vecs[i].em);
      chk($sformatf("v%0d_nomatch", i), nomatch, !vecs[i].em);
      chk($sformatf("v%0d_addr", i), match_addr, vecs[i].ea);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), done, 0);
    end

    // Write and start on the same edge: the compare at index 0 sees the write.
    do_reset();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h99;
    run_scan(8'h99, -1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, lat, bcnt);
    $display("same-edge write+start lat=%0d match=%0b addr=%0d", lat, match, match_addr);
    chk("same_edge_lat", lat, 1);
    chk("same_edge_match", match, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("match_held", match, 1);

    // Restart during scan is ignored; write lands ahead of the scan pointer.
    do_reset();
    run_scan(8'h11, 1, 1'b1, 4'd7, 8'h11, 1'b1, 8'h22, lat, bcnt);
    $display("ignored restart lat=%0d match=%0b addr=%0d", lat, match, match_addr);
    chk("restart_lat", lat, 8);
    chk("restart_match", match, 1);
    chk("restart_addr", match_addr, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("restart_not_queued", busy, 0);

    // Write lands on the same edge its entry is compared: old contents win.
    do_reset();
    run_scan(8'h44, 5, 1'b1, 4'd5, 8'h44, 1'b0, 8'h00, lat, bcnt);
    $display("rbw same index lat=%0d match=%0b", lat, match);
    chk("rbw_same_lat", lat, 16);
    chk("rbw_same_match", match, 0);
    do_reset();
    run_scan(8'h44, 5, 1'b1, 4'd6, 8'h44, 1'b0, 8'h00, lat, bcnt);
    $display("rbw next index lat=%0d match=%0b addr=%0d", lat, match, match_addr);
    chk("rbw_next_lat", lat, 7);
    chk("rbw_next_addr", match_addr, 6);

    // Asynchronous reset at idx=2 aborts the scan and clears the table.
    do_reset();
    do_write(4'd10, 8'h5A);
    @(negedge clk);
    start = 1'b1; key = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b0;
    #1;
    $display("async reset mid-scan busy=%0b done=%0b match=%0b nomatch=%0b", busy, done, match, nomatch);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_match", match, 0);
    chk("abort_nomatch", nomatch, 1);
    bcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) bcnt++;
    end
    chk("abort_no_done", bcnt, 0);
    @(negedge clk);
    reset = 1'b1;
    run_scan(8'h5A, -1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, lat, bcnt);
    $display("rescan after reset lat=%0d match=%0b", lat, match);
    chk("rescan_lat", lat, 16);
    chk("rescan_match", match, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/search_scan.md
SEARCH_SCAN -- requirements
Module: search_scan

Interface
REQ-001 Parameter A, default 4: table address width; table depth DEPTH = 2^A entries.
REQ-002 Parameter D, default 8: data/key width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe for table entry.
REQ-006 wr_addr  input  A  table entry index for write.
REQ-007 wr_data  input  D  data written to entry.
REQ-008 start  input  1  request a scan; sampled only in IDLE.
REQ-009 key  input  D  search key; captured on the accepted start edge.
REQ-010 busy  output  1  high while in SCAN.
REQ-011 done  output  1  one-cycle pulse at scan completion.
REQ-012 match  output  1  result: key found; held until next accepted start.
REQ-013 nomatch  output  1  always the complement of match.
REQ-014 match_addr  output  A  lowest index whose valid entry equals key; held with match.

Function
REQ-015 Table: DEPTH entries of D bits, each with a valid bit; wr_en=1 at an edge writes wr_data to entry wr_addr and sets its valid bit.
REQ-016 Unwritten entries (valid=0) never match, regardless of stored data or key value.
REQ-017 FSM states IDLE, SCAN, DONE; IDLE->SCAN on start=1, SCAN->DONE on hit or last index, DONE->IDLE unconditionally after one cycle.
REQ-018 On accepted start: key captured into internal register, index counter cleared to 0, match and match_addr cleared to 0.
REQ-019 In SCAN, one entry compared per cycle at index idx; idx increments by 1 per cycle, no wrap within a scan.
REQ-020 Hit at idx k: match=1, match_addr=k registered at the same edge that enters DONE; scan stops (lowest index wins).
REQ-021 No hit through idx DEPTH-1: match=0, match_addr=0, enter DONE.
REQ-022 Latency: start accepted at edge E0; hit at index k -> done high in cycle following edge E(k+1); miss -> done high after edge E(DEPTH).
REQ-023 done is high exactly while in DONE (one cycle); busy is high exactly while in SCAN.
REQ-024 start while in SCAN or DONE is ignored; no queueing.
REQ-025 Writes are accepted in every state; a compare reads the entry value present before the same-edge write (read-before-write).
REQ-026 Changes on key after the accepted start do not affect the running scan.
REQ-027 Simultaneous wr_en and start in IDLE: both take effect; the write is visible to compares from the next edge onward.

Reset
REQ-028 reset=0 forces immediately, independent of clk: state IDLE, idx 0, all valid bits 0, captured key 0.
REQ-029 Reset output values: busy 0, done 0, match 0, nomatch 1, match_addr 0.
REQ-030 Reset asserted mid-scan aborts the scan with no done pulse; table contents become invalid.

Structure
REQ-031 Package search_pkg holds the FSM state typedef (IDLE, SCAN, DONE) and default values of A and D.
REQ-032 Table storage plus valid bits in a sub-module search_table (write port, one combinational read port with valid flag); FSM, counter, key register and result registers in search_scan.

Verification
REQ-033 Reset, no writes, start with key=0x00 -> done pulse after edge E16 (A=4), match=0, nomatch=1, match_addr=0.
REQ-034 Write 0x5A at index 3 and 0x5A at index 9, start key=0x5A -> done after edge E4, match=1, match_addr=3, busy high for cycles 1..4.
REQ-035 Write 0xC3 at index 15 only, start key=0xC3 -> done after edge E16, match=1, match_addr=15.
REQ-036 Start key=0x11, pulse start again during SCAN with key=0x22, write 0x11 at index 7 while idx<7 -> second start ignored, match=1, match_addr=7.
REQ-037 Start key=0x5A, assert reset at idx=2 -> busy/done/match drop to 0 asynchronously, nomatch=1, no done pulse; rescan after reset finds no match.
